// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM port-A arbiter and its environment:
// CPU load/store handshake, fill-engine command, and BRAM port-A pins.
interface vram_port_arbiter_if;
    // CPU access handshake
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic        cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rdata;
    logic        cpu_err;

    // Fill engine command and status
    logic        fill_start;
    logic [14:0] fill_base;
    logic [14:0] fill_len;
    logic        fill_value;
    logic        fill_busy;
    logic        fill_done;

    // Port A of the five 4K x 1 block RAMs
    logic [4:0]  vram_en;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic        vram_wdata;
    logic [4:0]  vram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err,
        input  fill_start, fill_base, fill_len, fill_value,
        output fill_busy, fill_done,
        output vram_en, vram_we, vram_addr, vram_wdata,
        input  vram_rdata
    );

    // Environment side: CPU, fill command source and the BRAMs
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        output fill_start, fill_base, fill_len, fill_value,
        input  fill_busy, fill_done,
        input  vram_en, vram_we, vram_addr, vram_wdata,
        output vram_rdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// VRAM port-A arbiter: shares the CPU-side port of the five 4K x 1 VRAM
// banks between CPU loads/stores (window 0x1000-0x5FFF) and a built-in
// fill engine that paints a contiguous bit range.  All BRAM-facing and
// handshake outputs are registered.  A CPU grant decided in IDLE drives the
// BRAM pins in the next cycle; write/invalid accesses acknowledge two cycles
// after the grant, valid reads three cycles after it.  A pending fill that
// is being starved by back-to-back CPU traffic is forced a burst of up to
// FILL_BURST writes after STARVE_LIMIT consecutive CPU grants.
module vram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FILL_BURST   = 8
) (
    input logic               clk,
    input logic               reset,
    vram_port_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W  = $clog2(FILL_BURST + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX_C  = STREAK_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0]  BURST_LAST_C  = BURST_W'(FILL_BURST - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CPU_ISSUE = 3'd1,
        CPU_WAIT  = 3'd2,
        CPU_DONE  = 3'd3,
        FILL      = 3'd4
    } state_t;

    // Map address bits [14:12] to the one-hot bank enable; banks live at
    // indices 1..5, anything else is outside the VRAM window (all zero).
    function automatic logic [4:0] bank_onehot(input logic [14:0] addr);
        logic [4:0] oh;
        case (addr[14:12])
            3'd1:    oh = 5'b00001;
            3'd2:    oh = 5'b00010;
            3'd3:    oh = 5'b00100;
            3'd4:    oh = 5'b01000;
            3'd5:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    // FSM and latched CPU request
    state_t              state_r;
    logic [4:0]          cpu_oh_r;     // bank of the latched CPU access (0 = invalid)
    logic                cpu_we_r;
    logic                cpu_req_d_r;  // previous cpu_req, for rise detection during FILL
    logic [STREAK_W-1:0] streak_r;

    // Fill engine state
    logic                fill_busy_r;
    logic                fill_done_r;
    logic [14:0]         fill_ptr_r;
    logic [14:0]         fill_cnt_r;
    logic                fill_value_r;
    logic [BURST_W-1:0]  burst_r;

    // Registered outputs
    logic                cpu_ack_r;
    logic                cpu_rdata_r;
    logic                cpu_err_r;
    logic [4:0]          vram_en_r;
    logic                vram_we_r;
    logic [11:0]         vram_addr_r;
    logic                vram_wdata_r;

    // Combinational decisions
    logic [4:0]          req_oh_s;
    logic [4:0]          fill_oh_s;
    logic                fill_pending_s;
    logic                cpu_grant_s;
    logic                req_rise_s;
    logic                fill_last_s;
    logic                rd_bit_s;

    assign req_oh_s       = bank_onehot(bus.cpu_addr);
    assign fill_oh_s      = bank_onehot(fill_ptr_r);
    assign fill_pending_s = fill_busy_r && (fill_cnt_r != 15'd0);
    assign cpu_grant_s    = bus.cpu_req && (!fill_pending_s || (streak_r < STREAK_MAX_C));
    assign req_rise_s     = bus.cpu_req && !cpu_req_d_r;
    // The write issued this cycle is the last of the burst or of the whole fill
    assign fill_last_s    = (fill_cnt_r == 15'd1) || (burst_r == BURST_LAST_C);
    // Only the addressed bank's data-out is meaningful
    assign rd_bit_s       = |(bus.vram_rdata & cpu_oh_r);

    // Arbitration FSM, BRAM port sequencing, CPU handshake and fill bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cpu_oh_r     <= 5'd0;
            cpu_we_r     <= 1'b0;
            cpu_req_d_r  <= 1'b0;
            streak_r     <= '0;
            fill_busy_r  <= 1'b0;
            fill_done_r  <= 1'b0;
            fill_ptr_r   <= 15'd0;
            fill_cnt_r   <= 15'd0;
            fill_value_r <= 1'b0;
            burst_r      <= '0;
            cpu_ack_r    <= 1'b0;
            cpu_rdata_r  <= 1'b0;
            cpu_err_r    <= 1'b0;
            vram_en_r    <= 5'd0;
            vram_we_r    <= 1'b0;
            vram_addr_r  <= 12'd0;
            vram_wdata_r <= 1'b0;
        end else begin
            // Pulses and BRAM strobes default low every cycle; address and
            // write data simply hold.
            vram_en_r   <= 5'd0;
            vram_we_r   <= 1'b0;
            cpu_ack_r   <= 1'b0;
            cpu_err_r   <= 1'b0;
            fill_done_r <= 1'b0;
            cpu_req_d_r <= bus.cpu_req;

            // Fill command acceptance and completion.  Completion is seen one
            // cycle after the last write was issued, so fill_done and the
            // falling fill_busy coincide.  A zero-length fill never goes busy.
            if (fill_busy_r && (fill_cnt_r == 15'd0)) begin
                fill_busy_r <= 1'b0;
                fill_done_r <= 1'b1;
            end else if (!fill_busy_r && bus.fill_start) begin
                if (bus.fill_len == 15'd0) begin
                    fill_done_r <= 1'b1;
                end else begin
                    fill_busy_r  <= 1'b1;
                    fill_ptr_r   <= bus.fill_base;
                    fill_cnt_r   <= bus.fill_len;
                    fill_value_r <= bus.fill_value;
                end
            end else begin
                fill_busy_r <= fill_busy_r;
            end

            case (state_r)
                IDLE: begin
                    if (cpu_grant_s) begin
                        // Grant: drive the BRAM pins next cycle straight from
                        // the request; out-of-window accesses touch no bank.
                        cpu_oh_r     <= req_oh_s;
                        cpu_we_r     <= bus.cpu_we;
                        vram_en_r    <= req_oh_s;
                        vram_we_r    <= bus.cpu_we && (req_oh_s != 5'd0);
                        vram_addr_r  <= bus.cpu_addr[11:0];
                        vram_wdata_r <= bus.cpu_wdata;
                        if (fill_pending_s && (streak_r < STREAK_MAX_C)) begin
                            streak_r <= streak_r + STREAK_W'(1);
                        end else begin
                            streak_r <= streak_r;
                        end
                        state_r <= CPU_ISSUE;
                    end else if (fill_pending_s) begin
                        streak_r <= '0;
                        burst_r  <= '0;
                        state_r  <= FILL;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                CPU_ISSUE: begin
                    // BRAM samples at the end of this cycle.  Writes and
                    // invalid accesses need no data, so acknowledge next cycle.
                    if (cpu_we_r || (cpu_oh_r == 5'd0)) begin
                        cpu_ack_r <= 1'b1;
                        cpu_err_r <= (cpu_oh_r == 5'd0);
                        if (!cpu_we_r) begin
                            cpu_rdata_r <= 1'b1;
                        end else begin
                            cpu_rdata_r <= cpu_rdata_r;
                        end
                    end else begin
                        cpu_ack_r <= 1'b0;
                    end
                    state_r <= CPU_WAIT;
                end

                CPU_WAIT: begin
                    if (cpu_we_r || (cpu_oh_r == 5'd0)) begin
                        state_r <= IDLE;
                    end else begin
                        // Valid read: BRAM data is on vram_rdata now
                        cpu_rdata_r <= rd_bit_s;
                        cpu_ack_r   <= 1'b1;
                        state_r     <= CPU_DONE;
                    end
                end

                CPU_DONE: begin
                    state_r <= IDLE;
                end

                FILL: begin
                    if (req_rise_s) begin
                        // Yield to a newly arrived CPU request without issuing
                        // another write; pointer and count are untouched.
                        state_r <= IDLE;
                    end else begin
                        vram_en_r    <= fill_oh_s;
                        vram_we_r    <= (fill_oh_s != 5'd0);
                        vram_addr_r  <= fill_ptr_r[11:0];
                        vram_wdata_r <= fill_value_r;
                        fill_ptr_r   <= fill_ptr_r + 15'd1;
                        fill_cnt_r   <= fill_cnt_r - 15'd1;
                        burst_r      <= burst_r + BURST_W'(1);
                        if (fill_last_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= FILL;
                        end
                    end
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack    = cpu_ack_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.cpu_err    = cpu_err_r;
    assign bus.fill_busy  = fill_busy_r;
    assign bus.fill_done  = fill_done_r;
    assign bus.vram_en    = vram_en_r;
    assign bus.vram_we    = vram_we_r;
    assign bus.vram_addr  = vram_addr_r;
    assign bus.vram_wdata = vram_wdata_r;

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the CPU-side port (port A) of the five 4K x 1 VRAM block RAMs between two requesters:
  - CPU loads/stores decoded to the VRAM window 0x1000-0x5FFF.
  - A built-in fill engine that clears or paints a contiguous bit range of VRAM.
- Decodes bank select from address bits [14:12] and sequences the synchronous BRAM access.
- Returns read data and acknowledges with a single-cycle handshake.
- The VGA port (port B) is not touched.

Parameters:
- STARVE_LIMIT, 4: consecutive CPU grants allowed while a fill is pending before the fill is forced a burst.
- FILL_BURST, 8: maximum fill writes issued per fill grant.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- cpu_req, in, 1: CPU access request; held high until cpu_ack.
- cpu_we, in, 1: 1 = write, 0 = read; valid with cpu_req.
- cpu_addr, in, 15: byte/bit address; [14:12] selects bank, [11:0] selects bit.
- cpu_wdata, in, 1: write bit.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_rdata, out, 1: read bit; valid while cpu_ack=1, held otherwise.
- cpu_err, out, 1: high with cpu_ack when the address is outside the VRAM window.
- fill_start, in, 1: one-cycle pulse; latches fill_base, fill_len and fill_value.
- fill_base, in, 15: first address to fill.
- fill_len, in, 15: number of bits to write.
- fill_value, in, 1: bit written to every location.
- fill_busy, out, 1: fill in progress.
- fill_done, out, 1: one-cycle pulse at fill completion.
- vram_en, out, 5: one-hot bank enable (bank k = address[14:12] == k+1).
- vram_we, out, 1: write enable to all banks.
- vram_addr, out, 12: bit address within bank.
- vram_wdata, out, 1: write bit.
- vram_rdata, in, 5: port A data-out of banks 0..4 (BRAM synchronous read).

Behaviour:
- Reset (reset=0) forces, asynchronously:
  - All outputs to 0 (cpu_rdata=0, vram_en=0).
  - FSM to IDLE.
  - Fill aborted: fill_busy=0, no fill_done.
  - Streak counter to 0.
- All vram_* outputs are registered.
  - A grant decided in cycle G drives vram_* in G+1.
  - The BRAM samples at the end of G+1.
  - vram_rdata is valid in G+2.
- FSM states: IDLE, CPU_ISSUE, CPU_WAIT, CPU_DONE, FILL.
- IDLE:
  - If cpu_req and (fill not pending or streak < STARVE_LIMIT): latch cpu_addr, cpu_we and cpu_wdata; streak += 1 (saturating) only if a fill is pending; go to CPU_ISSUE.
  - Else if a fill is pending: streak := 0; go to FILL.
  - Else stay in IDLE.
- CPU_ISSUE:
  - Valid bank: drive the one-hot vram_en, vram_addr = addr[11:0], and vram_we/vram_wdata.
  - Invalid bank (index 0, 6 or 7): vram_en = 0, vram_we = 0.
  - Next state: CPU_WAIT.
- CPU_WAIT:
  - vram_en and vram_we return to 0.
  - A write, or any invalid-address access, pulses cpu_ack in this cycle (G+2) and goes to IDLE.
  - A valid read captures vram_rdata[bank] into cpu_rdata and goes to CPU_DONE.
- CPU_DONE: cpu_ack=1 with the captured cpu_rdata (G+3); go to IDLE.
- Invalid address on a read: cpu_rdata=1, cpu_err=1.
- cpu_req still high in the IDLE cycle after cpu_ack is treated as a new request.
- FILL:
  - Issues one write per cycle at address ptr with value fill_value; ptr increments and the remaining count decrements.
  - Writes to addresses outside 0x1000-0x5FFF are suppressed (vram_en=0) but still counted.
  - ptr wraps 0x7FFF -> 0x0000.
  - Leaves FILL after FILL_BURST writes, when the count reaches 0, or in the cycle after cpu_req rises. The write already issued completes; no partial state is lost.
  - The count reaching 0 pulses fill_done in the following cycle and clears fill_busy in the same cycle.
- fill_start:
  - Accepted only when fill_busy=0; ignored while busy.
  - With fill_len = 0: no writes, fill_busy stays 0, fill_done pulses the next cycle.
- Simultaneous cpu_req and fill_start in IDLE: the CPU is granted; the fill is latched and becomes pending.
- Minimum CPU latency from grant: write 2 cycles, read 3 cycles.

Test Plan:
- CPU write 0x1005 = 1, then read 0x1005 -> vram_en=5'b00001 and vram_addr=0x005 on the write; write ack at G+2; read ack at G+3 with cpu_rdata=1, cpu_err=0.
- CPU read 0x0800 and write 0x6000 -> vram_en never asserted; both ack at G+2 with cpu_err=1; read returns cpu_rdata=1.
- fill_base=0x1FFE, fill_len=4, fill_value=1, no CPU traffic:
  - Writes hit bank0 addresses 0xFFE and 0xFFF, then bank1 addresses 0x000 and 0x001 on consecutive cycles.
  - fill_done pulses once; fill_busy falls in the same cycle.
- Fill with fill_len=100 while the CPU issues back-to-back reads:
  - After 4 CPU grants, a burst of at most 8 fill writes occurs.
  - A CPU request arriving during the burst is served within 2 cycles.
  - Total fill writes = 100 with exactly one fill_done.
- fill_len=0 -> no vram_we; fill_done pulses one cycle after fill_start. A second fill_start while busy is ignored, so the write count matches only the first fill's length.
- Assert reset low in the middle of a fill and in the middle of a CPU read -> all outputs 0 immediately; after release no fill_done and no cpu_ack; the FSM accepts a new request in IDLE.
